// File: rtl/uart_pkg.sv
// Shared constants and encodings for the UART frame controller.
package uart_pkg;

    // Start-of-frame marker byte.
    localparam logic [7:0] SOF = 8'hAA;

    // Default maximum payload length in bytes (payload bus is 32 bits wide).
    localparam int MAX_LEN_DEFAULT = 4;

    // Parser states.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CMD     = 3'd1,
        ST_LEN     = 3'd2,
        ST_PAYLOAD = 3'd3,
        ST_CHK     = 3'd4,
        ST_HOLD    = 3'd5
    } state_t;

    // Error codes reported on err_code.
    typedef enum logic [1:0] {
        ERR_NONE     = 2'b00,
        ERR_CHECKSUM = 2'b01,
        ERR_LENGTH   = 2'b10,
        ERR_TIMEOUT  = 2'b11
    } err_code_t;

endpackage

// File: rtl/uart_frame_ctrl.sv
// UART frame parser: SOF, CMD, LEN, payload, XOR checksum.
// A checked frame is held on the outputs until the consumer acknowledges it.
module uart_frame_ctrl
    import uart_pkg::*;
#(
    parameter int TIMEOUT = 1023,
    parameter int MAX_LEN = MAX_LEN_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_ready,
    output logic        frame_valid,
    input  logic        frame_ack,
    output logic [7:0]  frame_cmd,
    output logic [2:0]  frame_len,
    output logic [31:0] frame_payload,
    output logic        err,
    output logic [1:0]  err_code,
    output logic        overrun
);

    // Counter is wide enough to hold TIMEOUT itself, so the compare is reached before any wrap.
    localparam int              CNT_W     = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
    localparam logic [7:0]       MAX_LEN_B = 8'(MAX_LEN);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [7:0]       r_chk;
    logic [7:0]       r_cmd;
    logic [2:0]       r_len;
    logic [2:0]       r_idx;
    logic [31:0]      r_payload;
    logic             r_valid;
    logic             r_err;
    logic [1:0]       r_err_code;
    logic             r_overrun;

    logic             w_in_frame;
    logic             w_timeout;
    logic             w_last_payload;
    logic             w_err;
    err_code_t        w_err_kind;
    logic             w_valid_set;
    logic             w_release;
    logic             w_overrun;

    assign w_in_frame     = (r_state == ST_CMD) || (r_state == ST_LEN) ||
                            (r_state == ST_PAYLOAD) || (r_state == ST_CHK);
    assign w_timeout      = w_in_frame && !rx_ready && (r_cnt == TIMEOUT_C);
    assign w_last_payload = (r_idx == (r_len - 3'd1));

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state is written with non-blocking assignments only.
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode plus the error, release and overrun strobes.
    always_comb begin
        // NOTE: every signal gets a default first so no latch is inferred.
        w_state_nxt = r_state;
        w_err       = 1'b0;
        w_err_kind  = ERR_NONE;
        w_valid_set = 1'b0;
        w_release   = 1'b0;
        w_overrun   = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (rx_ready && rx_data == SOF) w_state_nxt = ST_CMD;
            end
            ST_CMD: begin
                if (rx_ready) w_state_nxt = ST_LEN;
            end
            ST_LEN: begin
                if (rx_ready) begin
                    if (rx_data > MAX_LEN_B) begin
                        w_state_nxt = ST_IDLE;
                        w_err       = 1'b1;
                        w_err_kind  = ERR_LENGTH;
                    end else if (rx_data == 8'd0) begin
                        w_state_nxt = ST_CHK;
                    end else begin
                        w_state_nxt = ST_PAYLOAD;
                    end
                end
            end
            ST_PAYLOAD: begin
                if (rx_ready && w_last_payload) w_state_nxt = ST_CHK;
            end
            ST_CHK: begin
                if (rx_ready) begin
                    if (rx_data == r_chk) begin
                        w_state_nxt = ST_HOLD;
                        w_valid_set = 1'b1;
                    end else begin
                        w_state_nxt = ST_IDLE;
                        w_err       = 1'b1;
                        w_err_kind  = ERR_CHECKSUM;
                    end
                end
            end
            ST_HOLD: begin
                // An ack releases the frame; a byte in the same cycle is treated as an idle byte.
                if (frame_ack) begin
                    w_release   = 1'b1;
                    w_state_nxt = (rx_ready && rx_data == SOF) ? ST_CMD : ST_IDLE;
                end else if (rx_ready) begin
                    w_overrun = 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase

        // Inter-byte timeout overrides whatever the in-frame state decided.
        if (w_timeout) begin
            w_state_nxt = ST_IDLE;
            w_err       = 1'b1;
            w_err_kind  = ERR_TIMEOUT;
        end
    end

    // Inter-byte idle counter: runs only while inside a frame, cleared by every byte.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_in_frame && !rx_ready && !w_timeout) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end else begin
            r_cnt <= '0;
        end
    end

    // Byte capture: command, length, payload and running checksum.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cmd     <= '0;
            r_len     <= '0;
            r_idx     <= '0;
            r_payload <= '0;
            r_chk     <= '0;
        end else if (rx_ready) begin
            case (r_state)
                ST_CMD: begin
                    r_cmd <= rx_data;
                    r_chk <= rx_data;
                end
                ST_LEN: begin
                    r_chk     <= r_chk ^ rx_data;
                    r_len     <= rx_data[2:0];
                    r_idx     <= '0;
                    r_payload <= '0;  // bytes beyond LEN stay zero
                end
                ST_PAYLOAD: begin
                    r_chk <= r_chk ^ rx_data;
                    r_payload[{r_idx[1:0], 3'b000} +: 8] <= rx_data;
                    r_idx <= r_idx + 3'd1;
                end
                default: ;
            endcase
        end
    end

    // Output strobes and the held frame_valid / err_code status.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid    <= 1'b0;
            r_err      <= 1'b0;
            r_err_code <= ERR_NONE;
            r_overrun  <= 1'b0;
        end else begin
            r_err     <= w_err;
            r_overrun <= w_overrun;
            if (w_err) r_err_code <= w_err_kind;
            if (w_valid_set)    r_valid <= 1'b1;
            else if (w_release) r_valid <= 1'b0;
        end
    end

    assign frame_valid   = r_valid;
    assign frame_cmd     = r_cmd;
    assign frame_len     = r_len;
    assign frame_payload = r_payload;
    assign err           = r_err;
    assign err_code      = r_err_code;
    assign overrun       = r_overrun;

endmodule
